// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer between two core-side cache controllers
// and the single shared data memory port: IDLE -> ACCESS -> RESP -> IDLE.
module dmem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic [2:0]  c0_mask,
    output logic        c0_ack,
    output logic [31:0] c0_rdata,

    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c1_wdata,
    input  logic [2:0]  c1_mask,
    output logic        c1_ack,
    output logic [31:0] c1_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_mask,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        owner,
    output logic [1:0]  dbg_state
);

    // Handshake: a core raises cX_req with its command and holds it until cX_ack,
    // a single-cycle pulse carrying cX_rdata. The request is sampled only in IDLE;
    // a req still high in the cycle after the ack is taken as a new request.

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_owner;
    logic        r_busy;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_mem_mask;
    logic        r_mem_rd_en;
    logic        r_mem_wr_en;
    logic        r_c0_ack;
    logic [31:0] r_c0_rdata;
    logic        r_c1_ack;
    logic [31:0] r_c1_rdata;

    logic        w_any_req;
    logic        w_win;
    logic        w_win_we;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic [2:0]  w_win_mask;

    // On a tie the core that did not win last time is granted (w_win=1 means core1).
    assign w_any_req   = c0_req | c1_req;
    assign w_win       = c1_req & (~c0_req | ~r_last);
    assign w_win_we    = w_win ? c1_we    : c0_we;
    assign w_win_addr  = w_win ? c1_addr  : c0_addr;
    assign w_win_wdata = w_win ? c1_wdata : c0_wdata;
    assign w_win_mask  = w_win ? c1_mask  : c0_mask;

    // The mem_* registers double as the latched request: they hold the winner's
    // command for the whole ACCESS window and are cleared on leaving it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_mask  <= 3'd0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_c0_ack    <= 1'b0;
            r_c0_rdata  <= 32'd0;
            r_c1_ack    <= 1'b0;
            r_c1_rdata  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_win;
                        r_last      <= w_win;
                        r_we        <= w_win_we;
                        r_cnt       <= LP_WAIT;
                        r_busy      <= 1'b1;
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_mem_mask  <= w_win_mask;
                        r_mem_rd_en <= ~w_win_we;
                        r_mem_wr_en <= w_win_we & (LP_WAIT == 4'd0);
                        r_state     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt       <= r_cnt - 4'd1;
                        // A store strobes only in the final ACCESS cycle.
                        r_mem_wr_en <= r_we & (r_cnt == 4'd1);
                    end else begin
                        r_c0_ack    <= ~r_owner;
                        r_c1_ack    <= r_owner;
                        r_c0_rdata  <= (~r_owner & ~r_we) ? mem_rdata : 32'd0;
                        r_c1_rdata  <= ( r_owner & ~r_we) ? mem_rdata : 32'd0;
                        r_mem_addr  <= 32'd0;
                        r_mem_wdata <= 32'd0;
                        r_mem_mask  <= 3'd0;
                        r_mem_rd_en <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    r_c0_ack   <= 1'b0;
                    r_c1_ack   <= 1'b0;
                    r_c0_rdata <= 32'd0;
                    r_c1_rdata <= 32'd0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign c0_ack    = r_c0_ack;
    assign c0_rdata  = r_c0_rdata;
    assign c1_ack    = r_c1_ack;
    assign c1_rdata  = r_c1_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_mask  = r_mem_mask;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_wr_en = r_mem_wr_en;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign dbg_state = r_state;

    a_single_ack: assert property (@(posedge clk) disable iff (!reset) !(c0_ack && c1_ack));
    a_excl_en:    assert property (@(posedge clk) disable iff (!reset) !(mem_rd_en && mem_wr_en));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A uses WAIT_CYCLES=0, instance B WAIT_CYCLES=3,
// each backed by its own byte-lane memory model with combinational reads.
module tb_dmem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // ---------------- instance A signals (WAIT_CYCLES=0) ----------------
    logic        a_c0_req = 0, a_c0_we = 0;
    logic [31:0] a_c0_addr = 0, a_c0_wdata = 0;
    logic [2:0]  a_c0_mask = 0;
    logic        a_c0_ack;
    logic [31:0] a_c0_rdata;
    logic        a_c1_req = 0, a_c1_we = 0;
    logic [31:0] a_c1_addr = 0, a_c1_wdata = 0;
    logic [2:0]  a_c1_mask = 0;
    logic        a_c1_ack;
    logic [31:0] a_c1_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [2:0]  a_mem_mask;
    logic        a_mem_rd_en, a_mem_wr_en, a_busy, a_owner;
    logic [1:0]  a_dbg;

    // ---------------- instance B signals (WAIT_CYCLES=3) ----------------
    logic        b_c0_req = 0, b_c0_we = 0;
    logic [31:0] b_c0_addr = 0, b_c0_wdata = 0;
    logic [2:0]  b_c0_mask = 0;
    logic        b_c0_ack;
    logic [31:0] b_c0_rdata;
    logic        b_c1_req = 0, b_c1_we = 0;
    logic [31:0] b_c1_addr = 0, b_c1_wdata = 0;
    logic [2:0]  b_c1_mask = 0;
    logic        b_c1_ack;
    logic [31:0] b_c1_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_mem_mask;
    logic        b_mem_rd_en, b_mem_wr_en, b_busy, b_owner;
    logic [1:0]  b_dbg;

    dmem_arbiter #(.WAIT_CYCLES(0)) u_dut_a (
        .clk(clk), .reset(rst_n),
        .c0_req(a_c0_req), .c0_we(a_c0_we), .c0_addr(a_c0_addr), .c0_wdata(a_c0_wdata),
        .c0_mask(a_c0_mask), .c0_ack(a_c0_ack), .c0_rdata(a_c0_rdata),
        .c1_req(a_c1_req), .c1_we(a_c1_we), .c1_addr(a_c1_addr), .c1_wdata(a_c1_wdata),
        .c1_mask(a_c1_mask), .c1_ack(a_c1_ack), .c1_rdata(a_c1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_mask(a_mem_mask),
        .mem_rd_en(a_mem_rd_en), .mem_wr_en(a_mem_wr_en), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner), .dbg_state(a_dbg)
    );

    dmem_arbiter #(.WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .reset(rst_n),
        .c0_req(b_c0_req), .c0_we(b_c0_we), .c0_addr(b_c0_addr), .c0_wdata(b_c0_wdata),
        .c0_mask(b_c0_mask), .c0_ack(b_c0_ack), .c0_rdata(b_c0_rdata),
        .c1_req(b_c1_req), .c1_we(b_c1_we), .c1_addr(b_c1_addr), .c1_wdata(b_c1_wdata),
        .c1_mask(b_c1_mask), .c1_ack(b_c1_ack), .c1_rdata(b_c1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_mask(b_mem_mask),
        .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner), .dbg_state(b_dbg)
    );

    // ---------------- memory models (little-endian, funct3 lanes) ----------------
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] m);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (m)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return w;
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [1:0] a,
                                                input logic [2:0] m, input logic [31:0] d);
        logic [31:0] bm;
        case (m)
            3'b000:  bm = 32'h0000_00FF << {a, 3'b000};
            3'b001:  bm = 32'h0000_FFFF << {a, 3'b000};
            3'b010:  bm = 32'hFFFF_FFFF;
            default: bm = 32'h0;
        endcase
        return (old & ~bm) | ((d << {a, 3'b000}) & bm);
    endfunction

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    int wr_a = 0;
    int wr_b = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 32'd0;
                mem_b[i] <= 32'd0;
            end
        end else begin
            if (a_mem_wr_en) begin
                mem_a[a_mem_addr[7:2]] <= store_merge(mem_a[a_mem_addr[7:2]], a_mem_addr[1:0],
                                                      a_mem_mask, a_mem_wdata);
                wr_a <= wr_a + 1;
            end
            if (b_mem_wr_en) begin
                mem_b[b_mem_addr[7:2]] <= store_merge(mem_b[b_mem_addr[7:2]], b_mem_addr[1:0],
                                                      b_mem_mask, b_mem_wdata);
                wr_b <= wr_b + 1;
            end
        end
    end

    assign a_mem_rdata = load_ext(mem_a[a_mem_addr[7:2]], a_mem_addr[1:0], a_mem_mask);
    assign b_mem_rdata = load_ext(mem_b[b_mem_addr[7:2]], b_mem_addr[1:0], b_mem_mask);

    // ---------------- driver tasks ----------------
    // d: 0 = instance A, 1 = instance B (core0 only); c: core id
    task automatic drive(input int d, input int c, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] mask);
        if (d == 0 && c == 0) begin
            a_c0_req = req; a_c0_we = we; a_c0_addr = addr; a_c0_wdata = wdata; a_c0_mask = mask;
        end else if (d == 0) begin
            a_c1_req = req; a_c1_we = we; a_c1_addr = addr; a_c1_wdata = wdata; a_c1_mask = mask;
        end else begin
            b_c0_req = req; b_c0_we = we; b_c0_addr = addr; b_c0_wdata = wdata; b_c0_mask = mask;
        end
    endtask

    function automatic logic get_ack(input int d, input int c);
        if (d == 0) return (c == 0) ? a_c0_ack : a_c1_ack;
        return b_c0_ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int d, input int c);
        if (d == 0) return (c == 0) ? a_c0_rdata : a_c1_rdata;
        return b_c0_rdata;
    endfunction

    // One complete access; lat counts cycles from the grant edge to the ack cycle.
    task automatic do_access(input int d, input int c, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] mask,
                             output logic [31:0] rdata, output int lat,
                             output int n_rd, output int n_wr, output bit ok);
        rdata = 32'd0; lat = 0; n_rd = 0; n_wr = 0; ok = 1'b0;
        @(negedge clk);
        drive(d, c, 1'b1, we, addr, wdata, mask);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if ((d == 0) ? a_mem_rd_en : b_mem_rd_en) n_rd++;
            if ((d == 0) ? a_mem_wr_en : b_mem_wr_en) n_wr++;
            if (get_ack(d, c)) begin
                ok = 1'b1;
                rdata = get_rdata(d, c);
                break;
            end
        end
        drive(d, c, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        n_vec++; if ({a_busy, a_owner, a_c0_ack, a_c1_ack, a_mem_rd_en, a_mem_wr_en} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 000000",
                              {a_busy, a_owner, a_c0_ack, a_c1_ack, a_mem_rd_en, a_mem_wr_en}); end
        n_vec++; if ({a_mem_addr, a_c0_rdata, a_c1_rdata} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {a_mem_addr, a_c0_rdata, a_c1_rdata}); end
        n_vec++; if (a_dbg !== 2'd0) begin
            n_err++; $display("FAIL reset_state: got %0d want 0", a_dbg); end
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({b_busy, b_owner, b_mem_wr_en, b_dbg} !== 5'b0) begin
            n_err++; $display("FAIL reset_b: got %b want 00000", {b_busy, b_owner, b_mem_wr_en, b_dbg}); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; int lat, nr, nw; bit ok;
        do_access(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || lat != 2) begin
            n_err++; $display("FAIL st_lat: got ok=%0d lat=%0d want ok=1 lat=2", ok, lat); end
        n_vec++; if (nw != 1 || nr != 0 || rd !== 32'd0) begin
            n_err++; $display("FAIL st_en: got wr=%0d rd=%0d rdata=%h want 1 0 0", nw, nr, rd); end
        n_vec++; if (mem_a[4] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL st_mem: got %h want deadbeef", mem_a[4]); end
        do_access(0, 0, 1'b0, 32'h10, 32'd0, 3'b010, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || lat != 2 || nr != 1 || nw != 0) begin
            n_err++; $display("FAIL ld_lat: got ok=%0d lat=%0d rd=%0d wr=%0d want 1 2 1 0", ok, lat, nr, nw); end
        n_vec++; if (rd !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL ld_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int acks, prev;
        logic [31:0] exp_owner, got_owner;
        pulse_reset();
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        acks = 0; prev = 0;
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
        drive(0, 1, 1'b1, 1'b0, 32'h14, 32'd0, 3'b010);
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(negedge clk);
            if (a_c0_ack || a_c1_ack) begin
                got_owner = a_c1_ack ? 32'd1 : 32'd0;
                exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                n_vec++; if (got_owner !== exp_owner || (a_c0_ack && a_c1_ack)) begin
                    n_err++; $display("FAIL rr_order[%0d]: got c0=%b c1=%b want core %0d",
                                      acks, a_c0_ack, a_c1_ack, exp_owner); end
                n_vec++; if ((acks == 0 && i != 1) || (acks > 0 && i - prev != 3)) begin
                    n_err++; $display("FAIL rr_timing[%0d]: got cycle %0d prev %0d want 3 apart", acks, i, prev); end
                if (!a_c1_ack) begin
                    n_vec++; if (a_c0_rdata !== 32'hDEADBEEF || a_c1_rdata !== 32'd0) begin
                        n_err++; $display("FAIL rr_rdata: got c0=%h c1=%h want deadbeef 0", a_c0_rdata, a_c1_rdata); end
                end
                prev = i;
                acks++;
                if (acks == 4) begin
                    drive(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
                    drive(0, 1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
                end
            end
        end
        drive(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(0, 1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        n_vec++; if (acks != 4 || exp_q.size() != 0) begin
            n_err++; $display("FAIL rr_count: got %0d acks want 4", acks); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; int lat, nr, nw; bit ok;
        do_access(0, 1, 1'b1, 32'h10, 32'h11223344, 3'b010, rd, lat, nr, nw, ok);
        do_access(0, 1, 1'b1, 32'h13, 32'h000000AB, 3'b000, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || nw != 1) begin
            n_err++; $display("FAIL sb_store: got ok=%0d wr=%0d want 1 1", ok, nw); end
        do_access(0, 1, 1'b0, 32'h10, 32'd0, 3'b010, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || rd !== 32'hAB223344) begin
            n_err++; $display("FAIL sb_lw: got %h want ab223344", rd); end
        do_access(0, 1, 1'b0, 32'h13, 32'd0, 3'b000, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || rd !== 32'hFFFFFFAB) begin
            n_err++; $display("FAIL sb_lb: got %h want ffffffab", rd); end
        do_access(0, 1, 1'b0, 32'h13, 32'd0, 3'b100, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || rd !== 32'h000000AB) begin
            n_err++; $display("FAIL sb_lbu: got %h want 000000ab", rd); end
        do_access(0, 1, 1'b0, 32'h12, 32'd0, 3'b101, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || rd !== 32'h0000AB22) begin
            n_err++; $display("FAIL sb_lhu: got %h want 0000ab22", rd); end
    endtask

    task automatic test_wait_cycles();
        logic [31:0] rd; int lat, nr, nw; bit ok;
        do_access(1, 0, 1'b0, 32'h0, 32'd0, 3'b010, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || lat != 5 || nr != 4 || nw != 0) begin
            n_err++; $display("FAIL w3_load: got ok=%0d lat=%0d rd=%0d wr=%0d want 1 5 4 0", ok, lat, nr, nw); end
        do_access(1, 0, 1'b1, 32'h4, 32'h00000055, 3'b010, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || lat != 5 || nw != 1 || nr != 0) begin
            n_err++; $display("FAIL w3_store: got ok=%0d lat=%0d wr=%0d rd=%0d want 1 5 1 0", ok, lat, nw, nr); end
        do_access(1, 0, 1'b0, 32'h4, 32'd0, 3'b010, rd, lat, nr, nw, ok);
        n_vec++; if (!ok || rd !== 32'h00000055) begin
            n_err++; $display("FAIL w3_readback: got %h want 00000055", rd); end
    endtask

    task automatic test_ignore_changes();
        int nr, bad;
        bit ok;
        logic [31:0] rd;
        nr = 0; bad = 0; ok = 1'b0; rd = 32'd0;
        @(negedge clk);
        drive(1, 0, 1'b1, 1'b0, 32'h4, 32'd0, 3'b010);
        @(negedge clk);
        drive(1, 0, 1'b0, 1'b1, 32'h8, 32'h99, 3'b000);
        n_vec++; if (b_mem_addr !== 32'h4 || b_busy !== 1'b1) begin
            n_err++; $display("FAIL chg_first: got addr=%h busy=%b want 4 1", b_mem_addr, b_busy); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_mem_rd_en) begin
                nr++;
                if (b_mem_addr !== 32'h4 || b_mem_mask !== 3'b010 || b_mem_wr_en) bad++;
            end
            if (b_c0_ack) begin
                ok = 1'b1;
                rd = b_c0_rdata;
                break;
            end
        end
        n_vec++; if (bad != 0 || nr != 3) begin
            n_err++; $display("FAIL chg_addr: got %0d unstable of %0d rd cycles want 0 of 3", bad, nr); end
        n_vec++; if (!ok || rd !== 32'h00000055) begin
            n_err++; $display("FAIL chg_ack: got ok=%0d rdata=%h want 1 00000055", ok, rd); end
        drive(1, 0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (3) @(negedge clk);
        n_vec++; if (b_busy !== 1'b0 || b_c0_ack !== 1'b0) begin
            n_err++; $display("FAIL chg_idle: got busy=%b ack=%b want 0 0", b_busy, b_c0_ack); end
    endtask

    task automatic test_reset_abort();
        int wr_snap, seen;
        wr_snap = wr_b; seen = 0;
        @(negedge clk);
        drive(1, 0, 1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if ({b_mem_wr_en, b_busy, b_c0_ack, b_dbg} !== 5'b0) begin
            n_err++; $display("FAIL abort_now: got %b want 00000", {b_mem_wr_en, b_busy, b_c0_ack, b_dbg}); end
        @(negedge clk);
        drive(1, 0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_c0_ack || b_mem_wr_en) seen++;
        end
        n_vec++; if (seen != 0) begin
            n_err++; $display("FAIL abort_ack: got %0d ack/wr cycles want 0", seen); end
        n_vec++; if (wr_b != wr_snap || mem_b[8] !== 32'd0) begin
            n_err++; $display("FAIL abort_mem: got writes=%0d word=%h want %0d 0", wr_b, mem_b[8], wr_snap); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_byte_merge();
        test_wait_cycles();
        test_ignore_changes();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
